// File: rtl/digit_pixel_stage.sv
// Glyph pixel stage: turns a glyph-local offset plus digit value into a glyph ROM address,
// waits out the ROM latency, and emits a coloured pixel with matching sync/blank timing.
module digit_pixel_stage #(
  parameter int WIDTH        = 25,
  parameter int HEIGHT       = 52,
  parameter int ROM_AW       = 14,
  parameter int ROM_LAT      = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [10:0]       image_addr,
  input  logic              overlap,
  input  logic [3:0]        out_num,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic [23:0]       color_in,
  input  logic              blink_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_data,
  output logic [23:0]       pixel,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out
);

  localparam int GLYPH_SIZE = WIDTH * HEIGHT;
  localparam int CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [10:0]        addr_d;
  logic [ROM_AW-1:0]  rom_addr_nxt;
  logic               vld_b, hs_b, vs_b, bl_b;
  logic [ROM_LAT-1:0] vld_sr, hs_sr, vs_sr, bl_sr;
  logic               vld_d, hs_d, vs_d, bl_d;
  logic               vs_prev, vs_rise;
  logic [23:0]        color_q;
  logic [CNT_W-1:0]   blink_cnt;
  logic               phase, hide, lit;

  // Address arithmetic wraps at ROM_AW bits; out-of-range digits still drive an address.
  assign rom_addr_nxt = ROM_AW'(out_num) * ROM_AW'(GLYPH_SIZE) + ROM_AW'(addr_d);

  // Stage A realigns the early offset; stage B forms the address and the valid flag.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      addr_d   <= '0;
      rom_addr <= '0;
      vld_b    <= 1'b0;
      hs_b     <= 1'b0;
      vs_b     <= 1'b0;
      bl_b     <= 1'b1;
    end else begin
      addr_d   <= image_addr;
      rom_addr <= rom_addr_nxt;
      vld_b    <= overlap & (out_num <= 4'd9);
      hs_b     <= hsync_in;
      vs_b     <= vsync_in;
      bl_b     <= blank_in;
    end
  end

  // Delay line matching the ROM read latency; blank resets high so a flushed pipe stays blanked.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vld_sr <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
      bl_sr  <= '1;
    end else begin
      vld_sr[0] <= vld_b;
      hs_sr[0]  <= hs_b;
      vs_sr[0]  <= vs_b;
      bl_sr[0]  <= bl_b;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
        bl_sr[i]  <= bl_sr[i-1];
      end
    end
  end

  assign vld_d = vld_sr[ROM_LAT-1];
  assign hs_d  = hs_sr[ROM_LAT-1];
  assign vs_d  = vs_sr[ROM_LAT-1];
  assign bl_d  = bl_sr[ROM_LAT-1];

  assign vs_rise = vsync_in & ~vs_prev;

  // Frame-rate state: colour latch and blink phase both advance only on a vsync rising edge.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vs_prev   <= 1'b0;
      color_q   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (vs_rise) color_q <= color_in;
      if (!blink_en) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (vs_rise) begin
        if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign hide = blink_en & phase;
  assign lit  = vld_d & rom_data & ~bl_d & ~hide;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      pixel     <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b1;
    end else begin
      pixel     <= lit ? color_q : '0;
      hsync_out <= hs_d;
      vsync_out <= vs_d;
      blank_out <= bl_d;
    end
  end

endmodule

// File: tb/tb_digit_pixel_stage.sv
// Bench for digit_pixel_stage: glyph ROM model, queue-based reference model checked every cycle,
// directed probes with literal expectations, then randomized raster-like traffic with a mid-stream reset.
module tb_digit_pixel_stage;

  localparam int WIDTH        = 25;
  localparam int HEIGHT       = 52;
  localparam int ROM_AW       = 14;
  localparam int ROM_LAT      = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int ROM_DEPTH    = 1 << ROM_AW;

  logic              pixel_clk = 1'b0;
  logic              reset;
  logic [10:0]       image_addr;
  logic              overlap;
  logic [3:0]        out_num;
  logic              hsync_in, vsync_in, blank_in;
  logic [23:0]       color_in;
  logic              blink_en;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_data;
  logic [23:0]       pixel;
  logic              hsync_out, vsync_out, blank_out;

  int passed = 0;
  int total  = 0;

  digit_pixel_stage #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROM_AW(ROM_AW),
    .ROM_LAT(ROM_LAT), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .image_addr(image_addr),
    .overlap   (overlap),
    .out_num   (out_num),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .blank_in  (blank_in),
    .color_in  (color_in),
    .blink_en  (blink_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pixel     (pixel),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .blank_out (blank_out)
  );

  // ---------------- clock / reset ----------------
  always #5 pixel_clk = ~pixel_clk;

  // ---------------- glyph ROM (environment) ----------------
  bit   glyph [0:ROM_DEPTH-1];
  logic rom_q [ROM_LAT];

  always @(posedge pixel_clk) begin
    rom_q[0] <= glyph[rom_addr];
    for (int i = 1; i < ROM_LAT; i++) rom_q[i] <= rom_q[i-1];
  end
  assign rom_data = rom_q[ROM_LAT-1];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic              vld;
    logic              hs;
    logic              vs;
    logic              bl;
    logic [ROM_AW-1:0] addr;
  } item_t;

  item_t             pipe_q[$];
  logic [10:0]       m_prev_addr;
  logic              m_prev_vs;
  logic [23:0]       m_color;
  int                m_rises;
  logic [ROM_AW-1:0] exp_rom_addr;
  logic [23:0]       exp_pixel;
  logic              exp_hs, exp_vs, exp_bl;

  task automatic model_reset();
    item_t idle;
    idle = '{vld: 1'b0, hs: 1'b0, vs: 1'b0, bl: 1'b1, addr: '0};
    pipe_q = {};
    repeat (ROM_LAT + 1) pipe_q.push_back(idle);
    m_prev_addr  = '0;
    m_prev_vs    = 1'b0;
    m_color      = '0;
    m_rises      = 0;
    exp_rom_addr = '0;
    exp_pixel    = '0;
    exp_hs       = 1'b0;
    exp_vs       = 1'b0;
    exp_bl       = 1'b1;
  endtask

  // One pixel-clock step of the spec: whatever entered ROM_LAT+2 registers ago comes out now.
  task automatic model_step();
    item_t it, old;
    logic  rise, hide;
    it.vld  = overlap && (out_num <= 4'd9);
    it.hs   = hsync_in;
    it.vs   = vsync_in;
    it.bl   = blank_in;
    it.addr = ROM_AW'((int'(out_num) * WIDTH * HEIGHT + int'(m_prev_addr)) % ROM_DEPTH);
    exp_rom_addr = it.addr;
    old = pipe_q.pop_front();
    pipe_q.push_back(it);
    hide = blink_en && (((m_rises / BLINK_FRAMES) % 2) == 1);
    exp_pixel = (old.vld && glyph[old.addr] && !old.bl && !hide) ? m_color : 24'h0;
    exp_hs = old.hs;
    exp_vs = old.vs;
    exp_bl = old.bl;
    rise = vsync_in && !m_prev_vs;
    m_prev_vs = vsync_in;
    if (rise) m_color = color_in;
    if (!blink_en) m_rises = 0;
    else if (rise) m_rises++;
    m_prev_addr = image_addr;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge pixel_clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
  endtask

  initial begin
    forever begin
      @(negedge pixel_clk);
      check("rom_addr",  24'(rom_addr),  24'(exp_rom_addr));
      check("pixel",     pixel,          exp_pixel);
      check("hsync_out", 24'(hsync_out), 24'(exp_hs));
      check("vsync_out", 24'(vsync_out), 24'(exp_vs));
      check("blank_out", 24'(blank_out), 24'(exp_bl));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pulse_vsync();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  task automatic probe(input logic [10:0] a, input logic [3:0] n,
                       input logic [ROM_AW-1:0] ea, input logic [23:0] ep);
    image_addr = a;
    step();
    overlap    = 1'b1;
    out_num    = n;
    image_addr = '0;
    step();
    check("probe_rom_addr", 24'(rom_addr), 24'(ea));
    overlap = 1'b0;
    out_num = '0;
    repeat (ROM_LAT + 1) step();
    check("probe_pixel", pixel, ep);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rom_addr"},  24'(rom_addr),  24'h0);
    check({tag, "_pixel"},     pixel,          24'h0);
    check({tag, "_hsync_out"}, 24'(hsync_out), 24'h0);
    check({tag, "_vsync_out"}, 24'(vsync_out), 24'h0);
    check({tag, "_blank_out"}, 24'(blank_out), 24'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) glyph[i] = ($urandom_range(0, 3) != 0);
    glyph[3927]  = 1'b1;
    glyph[12999] = 1'b1;
    glyph[15627] = 1'b1;

    reset = 1'b1;
    image_addr = '0; overlap = 1'b0; out_num = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
    color_in = '0; blink_en = 1'b0;
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b0;
    repeat (ROM_LAT + 3) step();

    // Colour latch, address arithmetic, out-of-range digit.
    color_in = 24'hFF0000;
    pulse_vsync();
    probe(11'd27, 4'd3, 14'd3927, 24'hFF0000);
    color_in = 24'h00FF00;
    probe(11'd1299, 4'd9, 14'd12999, 24'hFF0000);
    probe(11'd27, 4'd12, 14'd15627, 24'h000000);
    pulse_vsync();
    probe(11'd27, 4'd3, 14'd3927, 24'h00FF00);

    // Blink with a two-frame half-period.
    blink_en = 1'b1;
    probe(11'd27, 4'd3, 14'd3927, 24'h00FF00);
    pulse_vsync();
    probe(11'd27, 4'd3, 14'd3927, 24'h00FF00);
    pulse_vsync();
    probe(11'd27, 4'd3, 14'd3927, 24'h000000);
    pulse_vsync();
    probe(11'd27, 4'd3, 14'd3927, 24'h000000);
    pulse_vsync();
    probe(11'd27, 4'd3, 14'd3927, 24'h00FF00);
    pulse_vsync();
    pulse_vsync();
    probe(11'd27, 4'd3, 14'd3927, 24'h000000);
    blink_en = 1'b0;
    probe(11'd27, 4'd3, 14'd3927, 24'h00FF00);

    // Randomized raster-like traffic with a reset pulse mid-line.
    for (int c = 0; c < 3000; c++) begin
      vsync_in   = (c % 120) < 3;
      hsync_in   = (c % 30) < 3;
      blank_in   = hsync_in || vsync_in || ($urandom_range(0, 9) == 0);
      overlap    = ($urandom_range(0, 1) == 1);
      out_num    = 4'($urandom_range(0, 15));
      image_addr = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 49) == 0) color_in = 24'($urandom);
      blink_en   = ((c / 500) % 2) == 0;
      if (c == 1700) begin
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
      end
      if (c == 1703) reset = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
